// File: rtl/rv64b_ise_arb.sv
// Two-port arbiter/sequencer for the shared roli/roliw/andn datapath.
// One op in flight at a time: IDLE -> EXEC (datapath cycle) -> RESP (hold until consumed).
module rv64b_ise_arb #(
    parameter bit RR = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [63:0] req0_rs1,
    input  logic [63:0] req0_rs2,
    input  logic [4:0]  req0_imm,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [63:0] req1_rs1,
    input  logic [63:0] req1_rs2,
    input  logic [4:0]  req1_imm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_rd,
    output logic        rsp_err,
    output logic [63:0] dp_rs1,
    output logic [63:0] dp_rs2,
    output logic [4:0]  dp_imm,
    output logic        dp_op_roli,
    output logic        dp_op_roliw,
    output logic        dp_op_andn,
    input  logic [63:0] dp_rd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [63:0] rs1_q, rs2_q;
    logic [4:0]  imm_q;
    logic        id_q;
    logic        last_q;
    logic        rsp_id_q, rsp_err_q;
    logic [63:0] rsp_rd_q;

    logic arb_en, pick1, accept, exec, op_ill;

    // Arbitration runs in IDLE and in the cycle a response is consumed,
    // so a pending request can follow a completed one with no bubble.
    assign arb_en = g_resetn && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign pick1  = (req0_valid && req1_valid) ? (RR && !last_q) : req1_valid;
    assign req0_ready = arb_en && req0_valid && !pick1;
    assign req1_ready = arb_en && req1_valid && pick1;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= pick1 ? req1_op  : req0_op;
                rs1_q  <= pick1 ? req1_rs1 : req0_rs1;
                rs2_q  <= pick1 ? req1_rs2 : req0_rs2;
                imm_q  <= pick1 ? req1_imm : req0_imm;
                id_q   <= pick1;
                last_q <= pick1;
            end
            if (state_q == EXEC) begin
                rsp_rd_q  <= op_ill ? '0 : dp_rd;
                rsp_err_q <= op_ill;
                rsp_id_q  <= id_q;
            end
        end
    end

    // Datapath lines are quiet outside EXEC so it only toggles when used.
    assign exec        = (state_q == EXEC);
    assign op_ill      = (op_q == 2'b11);
    assign dp_rs1      = exec ? rs1_q : '0;
    assign dp_rs2      = exec ? rs2_q : '0;
    assign dp_imm      = exec ? imm_q : '0;
    assign dp_op_roli  = exec && (op_q == 2'b00);
    assign dp_op_roliw = exec && (op_q == 2'b01);
    assign dp_op_andn  = exec && (op_q == 2'b10);

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rv64b_ise_arb.sv
// Directed bench: instance a uses round-robin, instance b fixed priority.
// The bench supplies the combinational datapath for each instance.
module tb_rv64b_ise_arb;

    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance a (RR=1)
    logic        a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
    logic [1:0]  a_req0_op, a_req1_op;
    logic [63:0] a_req0_rs1, a_req0_rs2, a_req1_rs1, a_req1_rs2;
    logic [4:0]  a_req0_imm, a_req1_imm;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_id, a_rsp_err;
    logic [63:0] a_rsp_rd, a_dp_rs1, a_dp_rs2, a_dp_rd;
    logic [4:0]  a_dp_imm;
    logic        a_dp_op_roli, a_dp_op_roliw, a_dp_op_andn, a_busy;

    // instance b (RR=0)
    logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [1:0]  b_req0_op, b_req1_op;
    logic [63:0] b_req0_rs1, b_req0_rs2, b_req1_rs1, b_req1_rs2;
    logic [4:0]  b_req0_imm, b_req1_imm;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_err;
    logic [63:0] b_rsp_rd, b_dp_rs1, b_dp_rs2, b_dp_rd;
    logic [4:0]  b_dp_imm;
    logic        b_dp_op_roli, b_dp_op_roliw, b_dp_op_andn, b_busy;

    rv64b_ise_arb #(.RR(1'b1)) u_a (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_op(a_req0_op),
        .req0_rs1(a_req0_rs1), .req0_rs2(a_req0_rs2), .req0_imm(a_req0_imm),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_op(a_req1_op),
        .req1_rs1(a_req1_rs1), .req1_rs2(a_req1_rs2), .req1_imm(a_req1_imm),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
        .rsp_rd(a_rsp_rd), .rsp_err(a_rsp_err),
        .dp_rs1(a_dp_rs1), .dp_rs2(a_dp_rs2), .dp_imm(a_dp_imm),
        .dp_op_roli(a_dp_op_roli), .dp_op_roliw(a_dp_op_roliw), .dp_op_andn(a_dp_op_andn),
        .dp_rd(a_dp_rd), .busy(a_busy)
    );

    rv64b_ise_arb #(.RR(1'b0)) u_b (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
        .req0_rs1(b_req0_rs1), .req0_rs2(b_req0_rs2), .req0_imm(b_req0_imm),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
        .req1_rs1(b_req1_rs1), .req1_rs2(b_req1_rs2), .req1_imm(b_req1_imm),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_rd(b_rsp_rd), .rsp_err(b_rsp_err),
        .dp_rs1(b_dp_rs1), .dp_rs2(b_dp_rs2), .dp_imm(b_dp_imm),
        .dp_op_roli(b_dp_op_roli), .dp_op_roliw(b_dp_op_roliw), .dp_op_andn(b_dp_op_andn),
        .dp_rd(b_dp_rd), .busy(b_busy)
    );

    // Rotate-left semantics; with no op selected the model returns junk so a
    // missing zeroing of illegal-op results would show up.
    function automatic logic [63:0] dp_model(input logic [63:0] rs1, input logic [63:0] rs2,
                                             input logic [4:0] imm, input logic o_roli,
                                             input logic o_roliw, input logic o_andn);
        logic [31:0] w;
        w = rs1[31:0];
        w = (w << imm) | (w >> (6'd32 - {1'b0, imm}));
        if (o_roli)       return (rs1 << imm) | (rs1 >> (7'd64 - {2'b00, imm}));
        else if (o_roliw) return {{32{w[31]}}, w};
        else if (o_andn)  return rs1 & ~rs2;
        else              return rs1 ^ rs2 ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    always_comb a_dp_rd = dp_model(a_dp_rs1, a_dp_rs2, a_dp_imm, a_dp_op_roli, a_dp_op_roliw, a_dp_op_andn);
    always_comb b_dp_rd = dp_model(b_dp_rs1, b_dp_rs2, b_dp_imm, b_dp_op_roli, b_dp_op_roliw, b_dp_op_andn);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_resetn = 1'b0;
        a_req0_valid = 1'b1; a_req0_op = 2'b00; a_req0_rs1 = '0; a_req0_rs2 = '0; a_req0_imm = '0;
        a_req1_valid = 1'b0; a_req1_op = 2'b00; a_req1_rs1 = '0; a_req1_rs2 = '0; a_req1_imm = '0;
        a_rsp_ready  = 1'b0;
        b_req0_valid = 1'b0; b_req0_op = 2'b00; b_req0_rs1 = '0; b_req0_rs2 = '0; b_req0_imm = '0;
        b_req1_valid = 1'b0; b_req1_op = 2'b00; b_req1_rs1 = '0; b_req1_rs2 = '0; b_req1_imm = '0;
        b_rsp_ready  = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;

        // reset state
        chk("rst_req0_ready", a_req0_ready, 0);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rsp_rd", a_rsp_rd, 0);
        chk("rst_rsp_id_err", {a_rsp_id, a_rsp_err}, 0);
        chk("rst_dp_ops", {a_dp_op_roli, a_dp_op_roliw, a_dp_op_andn}, 0);
        chk("rst_dp_rs", {a_dp_rs1 | a_dp_rs2}, 0);
        a_req0_valid = 1'b0;
        #2 g_resetn = 1'b1;
        step();

        // single roli on port 0
        a_req0_valid = 1'b1; a_req0_op = 2'b00; a_req0_rs1 = 64'h1; a_req0_imm = 5'd4;
        a_rsp_ready = 1'b1;
        #1;
        chk("roli_ready", {a_req0_ready, a_req1_ready}, 2'b10);
        step();
        a_req0_valid = 1'b0;
        chk("roli_exec_ops", {a_dp_op_roli, a_dp_op_roliw, a_dp_op_andn}, 3'b100);
        chk("roli_exec_rs1", a_dp_rs1, 64'h1);
        chk("roli_exec_imm", a_dp_imm, 5'd4);
        chk("roli_exec_busy_vld", {a_busy, a_rsp_valid}, 2'b10);
        step();
        chk("roli_rsp_valid", a_rsp_valid, 1);
        chk("roli_rsp_rd", a_rsp_rd, 64'h10);
        chk("roli_rsp_id_err", {a_rsp_id, a_rsp_err}, 2'b00);
        chk("roli_resp_dp_quiet", {a_dp_op_roli, a_dp_imm}, 0);
        step();
        chk("roli_idle", {a_busy, a_rsp_valid}, 0);

        // illegal op on port 1
        a_req1_valid = 1'b1; a_req1_op = 2'b11; a_req1_rs1 = 64'hDEAD; a_req1_rs2 = '0;
        #1;
        chk("ill_ready", {a_req0_ready, a_req1_ready}, 2'b01);
        step();
        a_req1_valid = 1'b0;
        chk("ill_exec_ops", {a_dp_op_roli, a_dp_op_roliw, a_dp_op_andn}, 3'b000);
        step();
        chk("ill_rsp_valid", a_rsp_valid, 1);
        chk("ill_rsp_rd", a_rsp_rd, 64'h0);
        chk("ill_rsp_id_err", {a_rsp_id, a_rsp_err}, 2'b11);
        step();

        // round-robin contention: grants 0,1,0,1
        a_req0_valid = 1'b1; a_req0_op = 2'b10; a_req0_rs1 = 64'hFF;   a_req0_rs2 = 64'h0F;
        a_req1_valid = 1'b1; a_req1_op = 2'b10; a_req1_rs1 = 64'hF0F0; a_req1_rs2 = 64'h00F0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), {a_req0_ready, a_req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            step();
            chk($sformatf("rr_exec%0d", i), {a_dp_op_andn, a_rsp_valid}, 2'b10);
            if (i == 3) begin
                a_req0_valid = 1'b0;
                a_req1_valid = 1'b0;
            end
            step();
            chk($sformatf("rr_rsp_rd%0d", i), a_rsp_rd, (i % 2 == 0) ? 64'hF0 : 64'hF000);
            chk($sformatf("rr_rsp_id%0d", i), {a_rsp_valid, a_rsp_id}, {1'b1, i[0]});
        end
        step();
        chk("rr_idle", a_busy, 0);

        // backpressure with roliw, port 1 pending behind it
        a_rsp_ready = 1'b0;
        a_req0_valid = 1'b1; a_req0_op = 2'b01; a_req0_rs1 = 64'h8000_0000; a_req0_imm = 5'd1;
        #1;
        chk("bp_ready", {a_req0_ready, a_req1_ready}, 2'b10);
        step();
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b1; a_req1_op = 2'b10;
        chk("bp_exec_ops", {a_dp_op_roli, a_dp_op_roliw, a_dp_op_andn}, 3'b010);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_rd%0d", i), a_rsp_rd, 64'h1);
            chk($sformatf("bp_hold_vld%0d", i), {a_rsp_valid, a_rsp_id, a_rsp_err}, 3'b100);
            chk($sformatf("bp_hold_ready%0d", i), {a_req0_ready, a_req1_ready}, 2'b00);
            step();
        end
        a_rsp_ready = 1'b1;
        #1;
        chk("bp_b2b_ready", {a_req0_ready, a_req1_ready}, 2'b01);
        step();
        a_req1_valid = 1'b0;
        chk("bp_b2b_exec", {a_busy, a_rsp_valid, a_dp_op_andn}, 3'b101);
        step();
        chk("bp_b2b_rsp", {a_rsp_valid, a_rsp_id}, 2'b11);
        chk("bp_b2b_rd", a_rsp_rd, 64'hF000);
        step();

        // reset during EXEC of a port-0 op (pointer then points at port 0)
        a_req0_valid = 1'b1; a_req0_op = 2'b00; a_req0_rs1 = 64'h3; a_req0_imm = 5'd2;
        step();
        a_req0_valid = 1'b0;
        chk("mid_exec_busy", a_busy, 1);
        #2 g_resetn = 1'b0;
        #1;
        chk("mid_rst_busy_vld", {a_busy, a_rsp_valid}, 0);
        chk("mid_rst_dp", {a_dp_op_roli, a_dp_op_roliw, a_dp_op_andn, a_dp_imm}, 0);
        chk("mid_rst_dp_rs1", a_dp_rs1, 0);
        step();
        g_resetn = 1'b1;
        step();
        chk("post_rst_quiet0", {a_busy, a_rsp_valid}, 0);
        step();
        chk("post_rst_quiet1", {a_busy, a_rsp_valid}, 0);
        a_req0_valid = 1'b1; a_req1_valid = 1'b1;
        #1;
        chk("post_rst_grant", {a_req0_ready, a_req1_ready}, 2'b10);
        step();
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        step();
        chk("post_rst_rsp", {a_rsp_valid, a_rsp_id}, 2'b10);
        chk("post_rst_rd", a_rsp_rd, 64'hC);
        step();

        // fixed priority instance: port 0 wins every time
        b_rsp_ready = 1'b1;
        b_req0_valid = 1'b1; b_req0_op = 2'b10; b_req0_rs1 = 64'hFF;   b_req0_rs2 = 64'h0F;
        b_req1_valid = 1'b1; b_req1_op = 2'b10; b_req1_rs1 = 64'hF0F0; b_req1_rs2 = 64'h00F0;
        #1;
        chk("fp_grant_first", {b_req0_ready, b_req1_ready}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            step();
            chk($sformatf("fp_rsp%0d", i), {b_rsp_valid, b_rsp_id}, 2'b10);
            chk($sformatf("fp_rd%0d", i), b_rsp_rd, 64'hF0);
            chk($sformatf("fp_grant%0d", i), {b_req0_ready, b_req1_ready}, 2'b10);
        end
        b_req0_valid = 1'b0;
        #1;
        chk("fp_port1_ready", {b_req0_ready, b_req1_ready}, 2'b01);
        step();
        b_req1_valid = 1'b0;
        step();
        chk("fp_port1_rsp", {b_rsp_valid, b_rsp_id}, 2'b11);
        chk("fp_port1_rd", b_rsp_rd, 64'hF000);
        step();
        chk("fp_idle", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
